// File: rtl/syzygy_adc_enc_gen.sv
// Encode-clock generator for SYZYGY ADC pods: divides the fabric clock into a 50% duty encode
// clock, drives one differential pair per channel, and supports continuous and burst runs.
module syzygy_adc_enc_gen #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned BURST_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic [CHANNELS-1:0]    chan_en,
    input  logic                   mode,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   done,
    output logic                   sample_strobe,
    output logic [BURST_WIDTH-1:0] sample_count,
    output logic [CHANNELS-1:0]    adc_encode_p,
    output logic [CHANNELS-1:0]    adc_encode_n
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   hc_q, hc_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [CHANNELS-1:0]    chan_en_q, chan_en_d;
    logic                   mode_q, mode_d;
    logic [BURST_WIDTH-1:0] burst_len_q, burst_len_d;
    logic [BURST_WIDTH-1:0] sample_count_q, sample_count_d;
    logic                   stop_pending_q, stop_pending_d;
    logic                   enc_q, enc_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic start_ok;
    logic half_end;
    logic run_end;

    // A zero-length burst is not a valid run and is dropped like a start while busy.
    assign start_ok = start && (state_q == StIdle) && !(mode && (burst_len == '0));
    assign half_end = (hc_q == div_q);
    // Runs only terminate at the end of a LOW half, so no runt pulse reaches the pods.
    assign run_end  = (state_q == StLow) && half_end &&
                      (stop_pending_q || stop || (mode_q && (sample_count_q == burst_len_q)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            hc_q           <= '0;
            div_q          <= '0;
            chan_en_q      <= '0;
            mode_q         <= 1'b0;
            burst_len_q    <= '0;
            sample_count_q <= '0;
            stop_pending_q <= 1'b0;
            enc_q          <= 1'b0;
            strobe_q       <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            hc_q           <= hc_d;
            div_q          <= div_d;
            chan_en_q      <= chan_en_d;
            mode_q         <= mode_d;
            burst_len_q    <= burst_len_d;
            sample_count_q <= sample_count_d;
            stop_pending_q <= stop_pending_d;
            enc_q          <= enc_d;
            strobe_q       <= strobe_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hc_d           = hc_q;
        div_d          = div_q;
        chan_en_d      = chan_en_q;
        mode_d         = mode_q;
        burst_len_d    = burst_len_q;
        sample_count_d = sample_count_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d        = StHigh;
                    hc_d           = '0;
                    div_d          = div;
                    chan_en_d      = chan_en;
                    mode_d         = mode;
                    burst_len_d    = burst_len;
                    sample_count_d = BURST_WIDTH'(1);
                end
            end
            StHigh: begin
                if (half_end) begin
                    state_d = StLow;
                    hc_d    = '0;
                end else begin
                    hc_d = hc_q + DIV_WIDTH'(1);
                end
            end
            StLow: begin
                if (half_end) begin
                    hc_d = '0;
                    if (run_end) begin
                        state_d = StIdle;
                    end else begin
                        state_d        = StHigh;
                        sample_count_d = sample_count_q + BURST_WIDTH'(1);
                    end
                end else begin
                    hc_d = hc_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            stop_pending_d = 1'b0;
        end else if (stop && (state_q != StIdle)) begin
            stop_pending_d = 1'b1;
        end else begin
            stop_pending_d = stop_pending_q;
        end

        enc_d    = (state_d == StHigh);
        strobe_d = (state_d == StHigh) && (state_q != StHigh);
        done_d   = run_end;
        busy_d   = (state_d != StIdle);
    end

    // Differential output buffer: disabled channels idle at p=0, n=1.
    always_comb begin
        adc_encode_p  = {CHANNELS{enc_q}} & chan_en_q;
        adc_encode_n  = ~adc_encode_p;
        busy          = busy_q;
        done          = done_q;
        sample_strobe = strobe_q;
        sample_count  = sample_count_q;
    end

endmodule

// File: tb/tb_syzygy_adc_enc_gen.sv
// Directed bench for syzygy_adc_enc_gen: per-cycle output vectors for burst, stop, mask,
// ignored-start and reset cases, plus a narrow-counter instance for the wrap case.
module tb_syzygy_adc_enc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  div;
    logic [1:0]  chan_en;
    logic        mode;
    logic [15:0] burst_len;
    logic        start;
    logic        stop;

    logic        busy, done, sample_strobe;
    logic [15:0] sample_count;
    logic [1:0]  adc_encode_p, adc_encode_n;

    logic        busy_w, done_w, sample_strobe_w;
    logic [3:0]  sample_count_w;
    logic [1:0]  adc_encode_p_w, adc_encode_n_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    syzygy_adc_enc_gen #(
        .CHANNELS    (2),
        .DIV_WIDTH   (8),
        .BURST_WIDTH (16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .div           (div),
        .chan_en       (chan_en),
        .mode          (mode),
        .burst_len     (burst_len),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .sample_strobe (sample_strobe),
        .sample_count  (sample_count),
        .adc_encode_p  (adc_encode_p),
        .adc_encode_n  (adc_encode_n)
    );

    syzygy_adc_enc_gen #(
        .CHANNELS    (2),
        .DIV_WIDTH   (8),
        .BURST_WIDTH (4)
    ) u_dut_w (
        .clk           (clk),
        .rst_n         (rst_n),
        .div           (div),
        .chan_en       (chan_en),
        .mode          (mode),
        .burst_len     (burst_len[3:0]),
        .start         (start),
        .stop          (stop),
        .busy          (busy_w),
        .done          (done_w),
        .sample_strobe (sample_strobe_w),
        .sample_count  (sample_count_w),
        .adc_encode_p  (adc_encode_p_w),
        .adc_encode_n  (adc_encode_n_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] d, input logic [1:0] m, input logic md,
                           input logic [15:0] bl);
        div       = d;
        chan_en   = m;
        mode      = md;
        burst_len = bl;
    endtask

    // Start in cycle 0, then compare {p, n, strobe, busy, done} against bit c of each vector.
    task automatic run_vec(input string tag, input logic [1:0] mask, input logic [15:0] enc_v,
                           input logic [15:0] str_v, input logic [15:0] busy_v,
                           input logic [15:0] done_v, input int ncyc, input int stop_cyc,
                           input int restart_cyc, input int rst_cyc);
        logic [1:0] ep;
        logic [6:0] exp_v;
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            ep    = {enc_v[c] & mask[1], enc_v[c] & mask[0]};
            exp_v = {ep, ~ep, str_v[c], busy_v[c], done_v[c]};
            check_eq($sformatf("%s_c%0d", tag, c),
                     {25'd0, adc_encode_p, adc_encode_n, sample_strobe, busy, done},
                     {25'd0, exp_v});
            start = 1'b0;
            stop  = (c == stop_cyc);
            rst_n = (c != rst_cyc);
            if (c == restart_cyc) begin
                start = 1'b1;
                set_cfg(8'd5, 2'b01, 1'b0, 16'd9);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        set_cfg(8'd0, 2'b00, 1'b0, 16'd0);
        tick();
        tick();
        check_eq("rst_outputs", {27'd0, adc_encode_p, adc_encode_n, sample_strobe},
                 {27'd0, 2'b00, 2'b11, 1'b0});
        check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check_eq("rst_count", {16'd0, sample_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Burst of 3, div=1; ignored start with changed config at cycle 3.
        set_cfg(8'd1, 2'b11, 1'b1, 16'd3);
        run_vec("burst", 2'b11, 16'h0666, 16'h0222, 16'h1FFE, 16'h2000, 14, 0, 3, 0);
        check_eq("burst_count", {16'd0, sample_count}, 32'd3);

        // Zero-length burst start is dropped; counter keeps its last value.
        set_cfg(8'd1, 2'b11, 1'b1, 16'd0);
        run_vec("zero_len", 2'b11, 16'h0, 16'h0, 16'h0, 16'h0, 4, 0, 0, 0);
        check_eq("zero_len_count", {16'd0, sample_count}, 32'd3);

        // Continuous div=2, stop mid HIGH of second period.
        set_cfg(8'd2, 2'b11, 1'b0, 16'd0);
        run_vec("stop", 2'b11, 16'h038E, 16'h0082, 16'h1FFE, 16'h2000, 14, 8, 0, 0);
        check_eq("stop_count", {16'd0, sample_count}, 32'd2);

        // Channel 1 masked, div=0 burst of 2.
        set_cfg(8'd0, 2'b01, 1'b1, 16'd2);
        run_vec("mask", 2'b01, 16'h000A, 16'h000A, 16'h001E, 16'h0020, 7, 0, 0, 0);
        check_eq("mask_count", {16'd0, sample_count}, 32'd2);

        // Reset during a continuous div=1 run truncates with no done.
        set_cfg(8'd1, 2'b11, 1'b0, 16'd0);
        run_vec("rst_mid", 2'b11, 16'h0026, 16'h0022, 16'h003E, 16'h0000, 9, 0, 0, 5);
        check_eq("rst_mid_count", {16'd0, sample_count}, 32'd0);

        set_cfg(8'd1, 2'b11, 1'b1, 16'd3);
        run_vec("post_rst", 2'b11, 16'h0666, 16'h0222, 16'h1FFE, 16'h2000, 14, 0, 0, 0);
        check_eq("post_rst_count", {16'd0, sample_count}, 32'd3);

        // Continuous div=0 for 20 periods on the 4-bit counter instance.
        set_cfg(8'd0, 2'b11, 1'b0, 16'd0);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            check_eq($sformatf("wrap_strobe_c%0d", c), {31'd0, sample_strobe_w},
                     {31'd0, c[0]});
            check_eq($sformatf("wrap_count_c%0d", c), {28'd0, sample_count_w},
                     ((c + 1) / 2) % 16);
            stop = (c == 39);
        end
        stop = 1'b0;
        tick();
        check_eq("wrap_done", {30'd0, done_w, busy_w}, {30'd0, 2'b10});
        check_eq("wrap_pairs", {28'd0, adc_encode_p_w, adc_encode_n_w}, {28'd0, 4'b0011});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/syzygy_adc_enc_gen.md
# syzygy_adc_enc_gen

Parametrised multi-channel ADC encode-clock generator for SYZYGY ADC pods. It derives a 50%-duty encode clock from the fabric clock by programmable integer division and drives one differential encode pair per channel through an OBUFDS. Continuous and fixed-length burst modes are supported, with glitch-free start and stop. A one-cycle sample strobe is aligned to each encode rising edge for the capture logic.

## Interface
- CHANNELS, 2, number of encode output pairs (1..8)
- DIV_WIDTH, 8, width of divide setting; encode period = 2*(div+1) clk cycles
- BURST_WIDTH, 16, width of burst length and sample counter
- clk  in  1  fabric clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- div  in  DIV_WIDTH  half-period minus one, latched on accepted start
- chan_en  in  CHANNELS  per-channel enable mask, latched on accepted start
- mode  in  1  0 = continuous, 1 = burst; latched on accepted start
- burst_len  in  BURST_WIDTH  encode rising edges per burst; latched on accepted start
- start  in  1  single-cycle request; accepted only when busy = 0
- stop  in  1  single-cycle request; ends run at next period boundary
- busy  out  1  high from first encode-high cycle through last encode-low cycle
- done  out  1  one-cycle pulse when a run ends (burst complete or stop)
- sample_strobe  out  1  one-cycle pulse coincident with each encode rising edge
- sample_count  out  BURST_WIDTH  rising edges since last accepted start; wraps modulo 2^BURST_WIDTH
- adc_encode_p  out  CHANNELS  differential encode, true leg
- adc_encode_n  out  CHANNELS  differential encode, complement leg

## Operation
- Registered encode level enc_q drives each channel's OBUFDS I as enc_q AND chan_en_latched[i]; disabled channels idle low (p=0, n=1).
- States: IDLE, HIGH, LOW. Half-cycle counter hc (DIV_WIDTH) counts 0..div_latched in HIGH and LOW.
- IDLE: enc_q=0, busy=0. start=1 (and not ignored) -> latch config, sample_count<=0 then 1, go HIGH, hc<=0.
- Ignored starts: mode=1 with burst_len=0; any start while busy=1. No state change, no done.
- Entry into HIGH: enc_q<=1, sample_strobe=1 for that cycle, sample_count increments.
- HIGH: when hc=div_latched -> LOW, hc<=0, enc_q<=0.
- LOW: when hc=div_latched -> if stop_pending, or (mode burst and sample_count=burst_len) -> IDLE with done=1; else -> HIGH.
- stop in HIGH or LOW sets stop_pending; run ends at end of current LOW half (no runt pulse). stop in IDLE ignored. stop_pending cleared on entry to IDLE.
- Simultaneous start and stop in IDLE: start accepted, stop ignored.
- div=0: encode period 2 clk cycles (enc_q toggles every cycle).

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, enc_q=0, busy=0, done=0, sample_strobe=0, sample_count=0, stop_pending=0, latched config cleared (chan_en_latched=0). All pairs p=0, n=1 from cycle after reset edge; reset mid-run truncates immediately without done.
- Start latency: start sampled at edge N -> enc_q=1, busy=1, sample_strobe=1 in cycle N+1.
- busy is a registered function of state (busy = state != IDLE); done asserts in the first IDLE cycle after the final LOW half, same cycle busy falls.
- Changes to div/chan_en/mode/burst_len while busy have no effect until next accepted start.
- Output pairs add only OBUFDS delay after enc_q; no extra register stages.

## Test plan
- Burst: div=1, mode=1, burst_len=3, chan_en=2'b11, start at cycle 0 -> enc high cycles 1-2, 5-6, 9-10; strobe at 1,5,9; busy 1..12; done at 13; sample_count=3.
- Continuous + stop: div=2, mode=0, start cycle 0, stop cycle 8 (mid HIGH of 2nd period) -> period 6, second period completes LOW at cycle 12, done at 13, no runt pulse; sample_count=2.
- Mask/idle: chan_en=2'b01, div=0 -> channel 0 toggles every cycle, channel 1 held p=0/n=1; after done both idle low.
- Ignored requests: burst_len=0 start -> busy stays 0, no done; start at cycle 3 during burst -> ignored, config change mid-run not applied.
- Reset mid-run: rst_n low at cycle 5 of continuous div=1 run -> cycle 6 all outputs at reset values, no done; subsequent start operates normally.
- Wrap: BURST_WIDTH=4, continuous div=0, run 20 periods -> sample_count wraps 15->0, strobe every 2 cycles uninterrupted.
